huffman_tree_ctrl: RTL and testbench

- Sequences the merge phase of the grayscale Huffman encoder.
- Inputs: the six symbol counts that the counting stage publishes with `CNT_valid`.
- Runs five find-two-minima / merge rounds over a six-slot group table and builds each symbol's code and mask on the fly.
- Presents `HC1..HC6` / `M1..M6` with a one-cycle `code_valid` pulse.

---
 rtl/huffman_pkg.sv | 18 +
 rtl/huffman_min2_scan.sv | 59 +++++
 rtl/huffman_tree_ctrl.sv | 143 ++++++++++++++
 tb/tb_huffman_tree_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared constants and FSM state type for the grayscale Huffman merge controller.
package huffman_pkg;

  localparam int NSYM   = 6;
  localparam int CNT_W  = 8;
  localparam int CODE_W = 8;
  localparam int LEN_W  = 3;
  localparam int ROUNDS = 5;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    MERGE,
    DONE
  } state_t;

endpackage

// File: rtl/huffman_min2_scan.sv
// Sequential two-minimum tracker: fed one table slot per cycle, keeps the
// smallest (min1) and second smallest (min2) active slots seen since start.
module huffman_min2_scan #(
  parameter int CNT_W = huffman_pkg::CNT_W,
  parameter int IDX_W = huffman_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [IDX_W-1:0] idx,
  input  logic             active,
  input  logic [CNT_W-1:0] weight,
  output logic [IDX_W-1:0] min1,
  output logic [IDX_W-1:0] min2
);

  logic [CNT_W-1:0] min1_w, min2_w;
  logic             min1_ok, min2_ok;
  logic             cur1_ok, cur2_ok, take1, take2;

  // Slots arrive in ascending index order, so a tie in weight means the
  // newcomer has the higher index and therefore ranks as the smaller one.
  always_comb begin
    cur1_ok = min1_ok && !start;
    cur2_ok = min2_ok && !start;
    take1   = active && (!cur1_ok || weight <= min1_w);
    take2   = active && !take1 && (!cur2_ok || weight <= min2_w);
  end

  // NOTE: non-blocking assignments so min2 captures the old min1 when min1 is displaced.
  always_ff @(posedge clk) begin
    if (reset) begin
      min1    <= '0;
      min2    <= '0;
      min1_w  <= '0;
      min2_w  <= '0;
      min1_ok <= 1'b0;
      min2_ok <= 1'b0;
    end else if (en) begin
      if (take1) begin
        min2    <= min1;
        min2_w  <= min1_w;
        min2_ok <= cur1_ok;
        min1    <= idx;
        min1_w  <= weight;
        min1_ok <= 1'b1;
      end else if (take2) begin
        min2    <= idx;
        min2_w  <= weight;
        min2_ok <= 1'b1;
      end else if (start) begin
        min1_ok <= 1'b0;
        min2_ok <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/huffman_tree_ctrl.sv
// Huffman merge-phase sequencer: five scan/merge rounds over a six-slot group
// table, growing each symbol's code and mask as its group is merged.
module huffman_tree_ctrl #(
  parameter int CNT_W  = huffman_pkg::CNT_W,
  parameter int CODE_W = huffman_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CNT_valid,
  input  logic [CNT_W-1:0]  CNT1,
  input  logic [CNT_W-1:0]  CNT2,
  input  logic [CNT_W-1:0]  CNT3,
  input  logic [CNT_W-1:0]  CNT4,
  input  logic [CNT_W-1:0]  CNT5,
  input  logic [CNT_W-1:0]  CNT6,
  output logic              busy,
  output logic              code_valid,
  output logic [CODE_W-1:0] HC1,
  output logic [CODE_W-1:0] HC2,
  output logic [CODE_W-1:0] HC3,
  output logic [CODE_W-1:0] HC4,
  output logic [CODE_W-1:0] HC5,
  output logic [CODE_W-1:0] HC6,
  output logic [CODE_W-1:0] M1,
  output logic [CODE_W-1:0] M2,
  output logic [CODE_W-1:0] M3,
  output logic [CODE_W-1:0] M4,
  output logic [CODE_W-1:0] M5,
  output logic [CODE_W-1:0] M6
);
  import huffman_pkg::*;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  scan_idx, round;
  logic [IDX_W-1:0]  min1, min2, lo, hi;
  logic              accept;

  logic [NSYM-1:0]   slot_act;
  logic [CNT_W-1:0]  slot_w   [NSYM];
  logic [NSYM-1:0]   slot_mem [NSYM];
  logic [CNT_W-1:0]  cnt      [NSYM];
  logic [CODE_W-1:0] hc       [NSYM];
  logic [CODE_W-1:0] m        [NSYM];
  logic [LEN_W-1:0]  len      [NSYM];

  logic [NSYM-1:0]   grp1, grp_u;
  logic [CNT_W-1:0]  w_sum;

  assign cnt = '{CNT1, CNT2, CNT3, CNT4, CNT5, CNT6};
  assign accept = (state == IDLE) && CNT_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    code_valid = 1'b0;
    case (state)
      IDLE:    if (CNT_valid) state_nxt = SCAN;
      SCAN:    if (scan_idx == IDX_W'(NSYM-1)) state_nxt = MERGE;
      MERGE:   state_nxt = (round == IDX_W'(ROUNDS-1)) ? DONE : SCAN;
      DONE: begin
        code_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      scan_idx <= '0;
      round    <= '0;
    end else if (state == SCAN) begin
      scan_idx <= (scan_idx == IDX_W'(NSYM-1)) ? '0 : scan_idx + IDX_W'(1);
    end else if (state == MERGE && round != IDX_W'(ROUNDS-1)) begin
      round <= round + IDX_W'(1);
    end
  end

  huffman_min2_scan #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_scan (
    .clk    (clk),
    .reset  (reset),
    .en     (state == SCAN),
    .start  (scan_idx == '0),
    .idx    (scan_idx),
    .active (slot_act[scan_idx]),
    .weight (slot_w[scan_idx]),
    .min1   (min1),
    .min2   (min2)
  );

  always_comb begin
    lo    = (min1 < min2) ? min1 : min2;
    hi    = (min1 < min2) ? min2 : min1;
    grp1  = slot_mem[min1];
    grp_u = slot_mem[min1] | slot_mem[min2];
    w_sum = slot_w[min1] + slot_w[min2];
  end

  // NOTE: the table is only six entries, so it is cleared on reset rather than left undefined.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_act <= '0;
      for (int i = 0; i < NSYM; i++) begin
        slot_w[i]   <= '0;
        slot_mem[i] <= '0;
        hc[i]       <= '0;
        m[i]        <= '0;
        len[i]      <= '0;
      end
    end else if (accept) begin
      slot_act <= '1;
      for (int i = 0; i < NSYM; i++) begin
        slot_w[i]   <= cnt[i];
        slot_mem[i] <= NSYM'(1) << i;
        hc[i]       <= '0;
        m[i]        <= '0;
        len[i]      <= '0;
      end
    end else if (state == MERGE) begin
      // min1 members take a 1 at their current length, min2 members a 0.
      for (int s = 0; s < NSYM; s++) begin
        if (grp_u[s]) begin
          m[s]   <= {m[s][CODE_W-2:0], 1'b1};
          len[s] <= len[s] + LEN_W'(1);
          if (grp1[s]) hc[s] <= hc[s] | (CODE_W'(1) << len[s]);
        end
      end
      slot_w[lo]   <= w_sum;
      slot_mem[lo] <= grp_u;
      slot_act[hi] <= 1'b0;
    end
  end

  assign {HC1, HC2, HC3, HC4, HC5, HC6} = {hc[0], hc[1], hc[2], hc[3], hc[4], hc[5]};
  assign {M1, M2, M3, M4, M5, M6}       = {m[0], m[1], m[2], m[3], m[4], m[5]};

endmodule

// File: tb/tb_huffman_tree_ctrl.sv
// Scoreboard bench for huffman_tree_ctrl: directed golden vectors plus random
// counts checked against a group-merging reference model.
module tb_huffman_tree_ctrl;

  typedef logic [5:0][7:0] vec_t;
  typedef struct packed {
    vec_t hc;
    vec_t m;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cnt_valid = 1'b0;
  vec_t       cnt = '0;
  logic       busy, code_valid;
  logic [7:0] hc [6];
  logic [7:0] m  [6];

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  huffman_tree_ctrl #(.CNT_W(8), .CODE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .CNT_valid  (cnt_valid),
    .CNT1       (cnt[0]),
    .CNT2       (cnt[1]),
    .CNT3       (cnt[2]),
    .CNT4       (cnt[3]),
    .CNT5       (cnt[4]),
    .CNT6       (cnt[5]),
    .busy       (busy),
    .code_valid (code_valid),
    .HC1        (hc[0]),
    .HC2        (hc[1]),
    .HC3        (hc[2]),
    .HC4        (hc[3]),
    .HC5        (hc[4]),
    .HC6        (hc[5]),
    .M1         (m[0]),
    .M2         (m[1]),
    .M3         (m[2]),
    .M4         (m[3]),
    .M5         (m[4]),
    .M6         (m[5])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    for (int s = 0; s < 6; s++) begin
      check($sformatf("%s HC%0d", tag, s + 1), 32'(hc[s]), 32'(e.hc[s]));
      check($sformatf("%s M%0d", tag, s + 1), 32'(m[s]), 32'(e.m[s]));
    end
  endtask

  function automatic vec_t mk(input logic [7:0] s1, s2, s3, s4, s5, s6);
    return {s6, s5, s4, s3, s2, s1};
  endfunction

  // Reference: repeatedly pick the two lightest groups (ties: higher slot is
  // lighter), prepend 1 to the lightest group's codes and 0 to the other's.
  function automatic exp_t model(input vec_t c);
    int       w[6];
    bit       act[6];
    bit [5:0] mem[6];
    int       len[6];
    int       a, b, lo, hi;
    exp_t     e;
    e = '0;
    for (int i = 0; i < 6; i++) begin
      w[i] = int'(c[i]);
      act[i] = 1'b1;
      mem[i] = 6'(1) << i;
      len[i] = 0;
    end
    for (int r = 0; r < 5; r++) begin
      a = -1;
      for (int i = 0; i < 6; i++)
        if (act[i] && (a < 0 || w[i] < w[a] || (w[i] == w[a] && i > a))) a = i;
      b = -1;
      for (int i = 0; i < 6; i++)
        if (act[i] && i != a && (b < 0 || w[i] < w[b] || (w[i] == w[b] && i > b))) b = i;
      for (int s = 0; s < 6; s++) begin
        if (mem[a][s]) e.hc[s] = e.hc[s] | 8'(1 << len[s]);
        if (mem[a][s] || mem[b][s]) begin
          e.m[s] = {e.m[s][6:0], 1'b1};
          len[s]++;
        end
      end
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      w[lo] = (w[a] + w[b]) % 256;
      mem[lo] = mem[a] | mem[b];
      act[hi] = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every code_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset && code_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected code_valid", 32'd1, 32'd0);
      end else begin
        check_outputs("result", sb.pop_front());
      end
    end
  end

  task automatic start(input vec_t c);
    @(negedge clk);
    cnt_valid = 1'b1;
    cnt = c;
    @(negedge clk);
    cnt_valid = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit dropped);
    n = 0;
    dropped = 1'b0;
    while (code_valid !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) dropped = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  function automatic vec_t rand_counts();
    vec_t c;
    for (int i = 0; i < 6; i++) begin
      c[i] = 8'($urandom_range(0, 16));
      if ($urandom_range(0, 3) == 0) c[i] = 8'd0;
    end
    return c;
  endfunction

  initial begin
    vec_t   v1, v2, ra, rb;
    exp_t   g1, g2, last;
    int     n;
    bit     dropped;
    longint t1, t2;

    v1 = mk(8'd40, 8'd30, 8'd10, 8'd10, 8'd6, 8'd4);
    v2 = mk(8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    g1.hc = mk(8'h01, 8'h00, 8'h03, 8'h04, 8'h0A, 8'h0B);
    g1.m  = mk(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F);
    g2.hc = mk(8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F);
    g2.m  = mk(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset code_valid", 32'(code_valid), 32'd0);
    check_outputs("reset", '0);

    // Golden vector 1 with latency and busy profile.
    sb.push_back(g1);
    start(v1);
    wait_done(n, dropped);
    check("latency v1", 32'(n), 32'd35);
    check("busy held v1", 32'(dropped), 32'd0);
    check("busy at code_valid", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy after code_valid", 32'(busy), 32'd0);
    check("code_valid one cycle", 32'(code_valid), 32'd0);

    // Golden vector 2 (zero weights, ties), then output hold.
    sb.push_back(g2);
    start(v2);
    wait_done(n, dropped);
    check("latency v2", 32'(n), 32'd35);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check_outputs($sformatf("hold %0d", k), g2);
    end

    // CNT_valid during a run is ignored.
    sb.push_back(g1);
    start(v1);
    repeat (9) @(negedge clk);
    cnt_valid = 1'b1;
    cnt = v2;
    @(negedge clk);
    cnt_valid = 1'b0;
    check("busy during ignored pulse", 32'(busy), 32'd1);
    wait_done(n, dropped);
    check("latency after ignored pulse", 32'(n), 32'd25);
    check("busy held ignored pulse", 32'(dropped), 32'd0);

    // Reset mid-run clears everything; a fresh run still matches.
    start(v1);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset code_valid", 32'(code_valid), 32'd0);
    check_outputs("midrun reset", '0);
    reset = 1'b0;
    sb.push_back(g1);
    start(v1);
    wait_done(n, dropped);
    check("latency after reset", 32'(n), 32'd35);

    // Back-to-back runs: second accepted the cycle after code_valid.
    ra = rand_counts();
    rb = rand_counts();
    sb.push_back(model(ra));
    start(ra);
    wait_done(n, dropped);
    t1 = $time;
    sb.push_back(model(rb));
    start(rb);
    wait_done(n, dropped);
    t2 = $time;
    check("back-to-back gap", 32'((t2 - t1) / 10), 32'd37);

    // Randomized runs with random idle gaps.
    for (int r = 0; r < 12; r++) begin
      ra = rand_counts();
      last = model(ra);
      sb.push_back(last);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start(ra);
      wait_done(n, dropped);
      check($sformatf("latency rand %0d", r), 32'(n), 32'd35);
      @(negedge clk);
      check_outputs($sformatf("rand hold %0d", r), last);
    end

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
